cdb_arbiter: RTL

- Write-back (common data bus) arbiter between N functional-unit result producers and the single register-file write-back port (wb data/tag/rd).
- Each requester has a one-entry pending buffer.
- One buffered result per cycle is granted round-robin and driven on registered wb outputs.
- Supports a synchronous flush on mispredict, which discards all in-flight results.

---
 rtl/cdb_pkg.sv | 24 ++
 rtl/rr_picker.sv | 31 +++
 rtl/cdb_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared common-data-bus types and default widths for the write-back path.
package cdb_pkg;

  localparam int unsigned CDB_N_REQ  = 4;
  localparam int unsigned CDB_DATA_W = 32;
  localparam int unsigned CDB_TAG_W  = 4;
  localparam int unsigned CDB_RD_W   = 5;

  // All-ones tag marks "no instruction"; such results are never written back.
  localparam logic [CDB_TAG_W-1:0] TAG_INVALID = '1;

  // One write-back payload, also used by the register-file write-back interface.
  typedef struct packed {
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_RD_W-1:0]   rd;
  } cdb_entry_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  int unsigned pos;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    pos   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = (32'(ptr) + off) % N;
      if (!any_c && req[IDX_W'(pos)]) begin
        any_c              = 1'b1;
        gnt_c[IDX_W'(pos)] = 1'b1;
        idx_c              = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Write-back arbiter: one-entry buffer per result producer, one grant per cycle
// onto registered wb outputs, synchronous flush on mispredict.
// Build option CDB_ARB_FIXED_PRIO_EN: requester 0 always wins when pending and
// the remaining requesters round-robin among themselves.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned N_REQ  = CDB_N_REQ,
  parameter int unsigned DATA_W = CDB_DATA_W,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned RD_W   = CDB_RD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*RD_W-1:0]   req_rd,
  output logic                    wb_valid,
  output logic [DATA_W-1:0]       wb_data,
  output logic [TAG_W-1:0]        wb_tag,
  output logic [RD_W-1:0]         wb_rd,
  output logic                    busy
);

  localparam int unsigned IDX_W = idx_w(N_REQ);
  localparam logic [TAG_W-1:0] TAG_INV = '1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [RD_W-1:0]   rd;
  } entry_t;

  entry_t             req_ent [N_REQ];
  entry_t             ent_q   [N_REQ];
  entry_t             wb_q, wb_d;
  logic               wb_valid_q, wb_valid_d;
  logic [N_REQ-1:0]   pend_q, pend_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   rr_mask, rr_gnt, gnt, accept, load;
  logic [IDX_W-1:0]   rr_idx, gnt_idx;
  logic               rr_any, gnt_any, ptr_upd;

  // Unpack flat request buses and qualify loads (invalid tags are swallowed).
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_ent[g].data = req_data[g*DATA_W +: DATA_W];
    assign req_ent[g].tag  = req_tag[g*TAG_W +: TAG_W];
    assign req_ent[g].rd   = req_rd[g*RD_W +: RD_W];
    assign load[g]         = accept[g] && (req_ent[g].tag != TAG_INV);
  end

  // A slot can accept when empty or being drained this cycle; never in flush/reset.
  assign req_ready = {N_REQ{!rst && !flush}} & (~pend_q | gnt);
  assign accept    = req_valid & req_ready;
  assign busy      = |pend_q;

  // Round-robin candidates: requester 0 is handled separately under fixed priority.
  always_comb begin
`ifdef CDB_ARB_FIXED_PRIO_EN
    rr_mask = pend_q & ~N_REQ'(1);
`else
    rr_mask = pend_q;
`endif
  end

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (rr_mask),
    .ptr   (ptr_q),
    .gnt_c (rr_gnt),
    .idx_c (rr_idx),
    .any_c (rr_any)
  );

  // Final grant selection; a requester-0 win leaves the rotation pointer alone.
  always_comb begin
    gnt     = rr_gnt;
    gnt_idx = rr_idx;
    gnt_any = rr_any;
    ptr_upd = rr_any;
`ifdef CDB_ARB_FIXED_PRIO_EN
    if (pend_q[0]) begin
      gnt     = N_REQ'(1);
      gnt_idx = '0;
      gnt_any = 1'b1;
      ptr_upd = 1'b0;
    end
`endif
  end

  // Next state: drain the granted slot, reload accepted slots, flush overrides all.
  always_comb begin
    pend_d     = (pend_q & ~gnt) | load;
    ptr_d      = ptr_q;
    wb_valid_d = 1'b0;
    wb_d       = wb_q;
    wb_d.tag   = TAG_INV;
    if (gnt_any) begin
      wb_valid_d = 1'b1;
      wb_d       = ent_q[gnt_idx];
    end
    if (ptr_upd) begin
      ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
    if (flush) begin
      pend_d     = '0;
      ptr_d      = '0;
      wb_valid_d = 1'b0;
      wb_d       = wb_q;
      wb_d.tag   = TAG_INV;
    end
  end

  // Control and write-back registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      ptr_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_q       <= '{data: '0, tag: TAG_INV, rd: '0};
    end else begin
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
    end
  end

  // Payload buffers; contents only matter while the matching pend bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (load[i]) ent_q[i] <= req_ent[i];
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_q.data;
  assign wb_tag   = wb_q.tag;
  assign wb_rd    = wb_q.rd;

endmodule
